// File: rtl/uart_word_sender.sv
// uart_word_sender
//
// Streams a block of 16-bit words from a synchronous-read word memory
// (IRAM or a monitor buffer) into the UART TX FIFO write port. It is used to
// dump program memory or monitored registers back to the host terminal.
//
// Each word is sent either as two raw bytes (MSB byte first) or, with
// HEX_ASCII=1, as four uppercase ASCII hex characters (MS nibble first)
// followed by CR and LF.
//
// Parameters:
//   WIDTH      word width; fixed at 16 (two bytes per word)
//   ADDR_BITS  memory address width
//   HEX_ASCII  0 = raw bytes, 1 = ASCII hex + CR/LF
//
// Ports:
//   clk_100MHz  system clock
//   rst         synchronous active-high reset; aborts any transfer at once
//   start       one-cycle start request, honoured only while idle
//   base_addr   first word address, latched on an accepted start
//   len         number of words, latched on an accepted start (0 allowed)
//   rd_en       memory read strobe
//   rd_addr     memory read address
//   rd_data     memory read data, valid one cycle after rd_en
//   tx_full     UART TX FIFO full
//   wr_uart     FIFO write strobe, one byte per high cycle
//   w_data      byte presented to the FIFO
//   busy        transfer in progress
//   done        one-cycle completion pulse
//   words_sent  words fully pushed in the current or last transfer

module uart_word_sender #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 8,
  parameter int HEX_ASCII = 0
) (
  input  logic                 clk_100MHz,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   len,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [7:0]           w_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   words_sent
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    NEXT = 3'd4,
    FIN  = 3'd5
  } state_t;

  // Index of the final byte of a word: 2 bytes raw, 6 bytes in hex mode.
  localparam logic [2:0]           LAST_IDX = (HEX_ASCII != 0) ? 3'd5 : 3'd1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_ZERO = '0;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     word_q;
  logic [2:0]           byte_idx;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [ADDR_BITS:0]   remaining;

  // Nibble to uppercase ASCII hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'd0, n};
    else           c = 8'h37 + {4'd0, n};
    return c;
  endfunction

  // Byte number idx of the serialised form of word w.
  function automatic logic [7:0] sel_byte(input logic [WIDTH-1:0] w,
                                          input logic [2:0]       idx);
    logic [7:0] b;
    b = 8'h00;
    if (HEX_ASCII != 0) begin
      case (idx)
        3'd0:    b = hex_char(w[15:12]);
        3'd1:    b = hex_char(w[11:8]);
        3'd2:    b = hex_char(w[7:4]);
        3'd3:    b = hex_char(w[3:0]);
        3'd4:    b = 8'h0D;
        3'd5:    b = 8'h0A;
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    b = w[15:8];
        3'd1:    b = w[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and strobes. wr_uart is combinational so a full FIFO
  // suppresses the write in the very cycle it is reported.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_uart   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    rd_addr   = addr_cnt;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == CNT_ZERO) ? FIN : READ;
      end
      READ: begin
        rd_en     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = SEND;
      SEND: begin
        wr_uart = ~tx_full;
        if (!tx_full && byte_idx == LAST_IDX) state_nxt = NEXT;
      end
      NEXT: state_nxt = (remaining == CNT_ONE) ? FIN : READ;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address/length counters, word capture and byte serialiser.
  // w_data is registered one step ahead of the write so it is stable for
  // the whole SEND cycle and back-to-back bytes need no gap.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      word_q     <= '0;
      byte_idx   <= 3'd0;
      addr_cnt   <= '0;
      remaining  <= '0;
      w_data     <= 8'h00;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_cnt   <= base_addr;
            remaining  <= len;
            words_sent <= '0;
          end
        end
        // --- read data returns: capture word, preload first byte ---
        WAIT: begin
          word_q   <= rd_data;
          byte_idx <= 3'd0;
          w_data   <= sel_byte(rd_data, 3'd0);
        end
        // --- byte stream: advance only on an accepted write ---
        SEND: begin
          if (wr_uart) begin
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx != LAST_IDX) w_data <= sel_byte(word_q, byte_idx + 3'd1);
          end
        end
        // --- word retired: addresses wrap naturally modulo 2^ADDR_BITS ---
        NEXT: begin
          words_sent <= words_sent + CNT_ONE;
          remaining  <= remaining - CNT_ONE;
          addr_cnt   <= addr_cnt + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed testbench for uart_word_sender: one raw-mode instance and one
// hex-mode instance, each with its own synchronous-read word memory.

module tb_uart_word_sender;

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic rst;

  // Raw-mode instance (a)
  logic        start_a;
  logic [7:0]  base_a;
  logic [8:0]  len_a;
  logic        rd_en_a;
  logic [7:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic        tx_full_a;
  logic        wr_uart_a;
  logic [7:0]  w_data_a;
  logic        busy_a;
  logic        done_a;
  logic [8:0]  ws_a;

  // Hex-mode instance (b)
  logic        start_b;
  logic [7:0]  base_b;
  logic [8:0]  len_b;
  logic        rd_en_b;
  logic [7:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        tx_full_b;
  logic        wr_uart_b;
  logic [7:0]  w_data_b;
  logic        busy_b;
  logic        done_b;
  logic [8:0]  ws_b;

  uart_word_sender #(.WIDTH(16), .ADDR_BITS(8), .HEX_ASCII(0)) dut_a (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .start      (start_a),
    .base_addr  (base_a),
    .len        (len_a),
    .rd_en      (rd_en_a),
    .rd_addr    (rd_addr_a),
    .rd_data    (rd_data_a),
    .tx_full    (tx_full_a),
    .wr_uart    (wr_uart_a),
    .w_data     (w_data_a),
    .busy       (busy_a),
    .done       (done_a),
    .words_sent (ws_a)
  );

  uart_word_sender #(.WIDTH(16), .ADDR_BITS(8), .HEX_ASCII(1)) dut_b (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .start      (start_b),
    .base_addr  (base_b),
    .len        (len_b),
    .rd_en      (rd_en_b),
    .rd_addr    (rd_addr_b),
    .rd_data    (rd_data_b),
    .tx_full    (tx_full_b),
    .wr_uart    (wr_uart_b),
    .w_data     (w_data_b),
    .busy       (busy_b),
    .done       (done_b),
    .words_sent (ws_b)
  );

  // Synchronous-read memories
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  always @(posedge clk_100MHz) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  // Observation log, sampled on the falling edge
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = -1;
  int         done_cnt_a = 0;
  int         done_cnt_b = 0;
  int         stall_n = 0;
  int         stall_bad = 0;
  logic [7:0] wb_a[$];
  int         wc_a[$];
  logic [7:0] ra_a[$];
  logic [7:0] wb_b[$];

  initial begin
    forever begin
      @(negedge clk_100MHz);
      cyc++;
      if (start_a && !busy_a) start_cyc = cyc;
      if (wr_uart_a) begin
        wb_a.push_back(w_data_a);
        wc_a.push_back(cyc - start_cyc);
      end
      if (rd_en_a) ra_a.push_back(rd_addr_a);
      if (done_a) begin
        done_cnt_a++;
        done_cyc = cyc - start_cyc;
      end
      if (tx_full_a) begin
        stall_n++;
        if (wr_uart_a !== 1'b0 || w_data_a !== 8'h34) stall_bad++;
      end
      if (wr_uart_b) wb_b.push_back(w_data_b);
      if (done_b) done_cnt_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic clear_logs();
    wb_a.delete();
    wc_a.delete();
    ra_a.delete();
    wb_b.delete();
    done_cnt_a = 0;
    done_cnt_b = 0;
    done_cyc   = -1;
    stall_n    = 0;
    stall_bad  = 0;
  endtask

  initial begin
    rst       = 1'b1;
    start_a   = 1'b0; base_a = 8'h00; len_a = 9'd0; tx_full_a = 1'b0;
    start_b   = 1'b0; base_b = 8'h00; len_b = 9'd0; tx_full_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[8'h10] = 16'h1234;
    mem_a[8'h11] = 16'hABCD;
    mem_a[8'hFF] = 16'hBEEF;
    mem_a[8'h00] = 16'hC0DE;
    mem_a[8'h30] = 16'h1111;
    mem_a[8'h31] = 16'h2222;
    mem_a[8'h32] = 16'h3333;
    mem_a[8'h33] = 16'h4444;
    mem_b[8'h20] = 16'h0A5F;

    // Reset state
    repeat (3) tick();
    check("rst_rd_en",   rd_en_a,   1'b0);
    check("rst_rd_addr", rd_addr_a, 8'h00);
    check("rst_wr_uart", wr_uart_a, 1'b0);
    check("rst_w_data",  w_data_a,  8'h00);
    check("rst_busy",    busy_a,    1'b0);
    check("rst_done",    done_a,    1'b0);
    check("rst_words",   ws_a,      9'd0);
    rst = 1'b0;
    tick();

    // Raw mode, two words, no backpressure
    clear_logs();
    base_a = 8'h10; len_a = 9'd2; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check("t1_busy_mid", busy_a, 1'b1);
    repeat (20) tick();
    check("t1_nbytes", wb_a.size(), 4);
    check("t1_b0", wb_a[0], 8'h12);
    check("t1_b1", wb_a[1], 8'h34);
    check("t1_b2", wb_a[2], 8'hAB);
    check("t1_b3", wb_a[3], 8'hCD);
    check("t1_first_lat", wc_a[0], 3);
    check("t1_b1_cyc", wc_a[1], 4);
    check("t1_b2_cyc", wc_a[2], 8);
    check("t1_done_cnt", done_cnt_a, 1);
    check("t1_done_cyc", done_cyc, 11);
    check("t1_words", ws_a, 9'd2);
    check("t1_busy_end", busy_a, 1'b0);

    // Backpressure: FIFO full for 5 cycles from the second byte
    clear_logs();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    tx_full_a = 1'b1;
    repeat (5) tick();
    tx_full_a = 1'b0;
    repeat (15) tick();
    check("t2_nbytes", wb_a.size(), 4);
    check("t2_b0", wb_a[0], 8'h12);
    check("t2_b1", wb_a[1], 8'h34);
    check("t2_b2", wb_a[2], 8'hAB);
    check("t2_b3", wb_a[3], 8'hCD);
    check("t2_b1_cyc", wc_a[1], 9);
    check("t2_b2_cyc", wc_a[2], 13);
    check("t2_b3_cyc", wc_a[3], 14);
    check("t2_stall_cycles", stall_n, 5);
    check("t2_stall_hold", stall_bad, 0);
    check("t2_done_cnt", done_cnt_a, 1);

    // Zero-length transfer
    clear_logs();
    len_a = 9'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    check("t3_no_read", ra_a.size(), 0);
    check("t3_no_write", wb_a.size(), 0);
    check("t3_done_cnt", done_cnt_a, 1);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_words", ws_a, 9'd0);

    // Address wrap, starts while busy (mid-transfer and in the FIN cycle)
    clear_logs();
    base_a = 8'hFF; len_a = 9'd2; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (2) tick();
    base_a = 8'h10; len_a = 9'd1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();
    check("t4_fin_cycle", done_a, 1'b1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    check("t4_nreads", ra_a.size(), 2);
    check("t4_addr0", ra_a[0], 8'hFF);
    check("t4_addr1", ra_a[1], 8'h00);
    check("t4_done_cnt", done_cnt_a, 1);
    check("t4_nbytes", wb_a.size(), 4);
    check("t4_b0", wb_a[0], 8'hBE);
    check("t4_b3", wb_a[3], 8'hDE);
    check("t4_words", ws_a, 9'd2);
    check("t4_busy_end", busy_a, 1'b0);

    // Hex ASCII mode
    clear_logs();
    base_b = 8'h20; len_b = 9'd1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (15) tick();
    check("t5_nbytes", wb_b.size(), 6);
    check("t5_c0", wb_b[0], 8'h30);
    check("t5_c1", wb_b[1], 8'h41);
    check("t5_c2", wb_b[2], 8'h35);
    check("t5_c3", wb_b[3], 8'h46);
    check("t5_cr", wb_b[4], 8'h0D);
    check("t5_lf", wb_b[5], 8'h0A);
    check("t5_words", ws_b, 9'd1);
    check("t5_done_cnt", done_cnt_b, 1);

    // Reset mid-transfer, then a clean rerun
    clear_logs();
    base_a = 8'h30; len_a = 9'd4; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("t6_pre_b0", wb_a[0], 8'h11);
    check("t6_pre_b1", wb_a[1], 8'h11);
    check("t6_pre_b2", wb_a[2], 8'h22);
    check("t6_rd_en",   rd_en_a,   1'b0);
    check("t6_rd_addr", rd_addr_a, 8'h00);
    check("t6_wr_uart", wr_uart_a, 1'b0);
    check("t6_w_data",  w_data_a,  8'h00);
    check("t6_busy",    busy_a,    1'b0);
    check("t6_done",    done_a,    1'b0);
    check("t6_words",   ws_a,      9'd0);
    rst = 1'b0;
    clear_logs();
    repeat (10) tick();
    check("t6_no_write_after", wb_a.size(), 0);
    check("t6_no_read_after", ra_a.size(), 0);
    clear_logs();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (30) tick();
    check("t6_re_nbytes", wb_a.size(), 8);
    check("t6_re_b0", wb_a[0], 8'h11);
    check("t6_re_b3", wb_a[3], 8'h22);
    check("t6_re_b4", wb_a[4], 8'h33);
    check("t6_re_b7", wb_a[7], 8'h44);
    check("t6_re_words", ws_a, 9'd4);
    check("t6_re_done", done_cnt_a, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
